ai_final_multi: RTL

Multi-channel end-of-utterance verdict block for the speech comparer. It sits after the per-character classifiers. After an `init` per channel it counts `char_rdy` events and watches for inactivity. On timeout it concludes that channel: it compares the count against a length-derived threshold, latches a sticky not-detected error, and raises a level interrupt until software acknowledges it.

---
 rtl/ai_final_pkg.sv | 33 +++
 rtl/ai_final_chan.sv | 129 ++++++++++++
 rtl/ai_final_multi.sv | 56 +++++
 3 files changed

// File: rtl/ai_final_pkg.sv
// Shared types and helpers for the end-of-utterance verdict block.
// Optional overrun detection is enabled with AI_FINAL_OVERRUN_EN.
package ai_final_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } ai_state_t;

    localparam int MAX_W = 64;

    function automatic int cnt_width(input int len_w, input int frac_shift);
        return len_w + frac_shift;
    endfunction

    // base << shift, clamped to the all-ones value of a width-bit field
    function automatic logic [MAX_W-1:0] sat_bound(
        input logic [MAX_W-1:0] base,
        input int               shift,
        input int               width
    );
        logic [MAX_W-1:0] lim;
        logic [MAX_W-1:0] v;
        lim = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        if (base > (lim >> shift))
            v = lim;
        else
            v = base << shift;
        return v;
    endfunction

endpackage

// File: rtl/ai_final_chan.sv
// One comparer channel: FSM, event counter, idle timer, bounds, sticky flags.
// AI_FINAL_OVERRUN_EN adds the ovr_err flag.
module ai_final_chan
    import ai_final_pkg::*;
#(
    parameter int LEN_W      = 16,
    parameter int FRAC_SHIFT = 9,
    parameter int TIMEOUT    = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] len,
    input  logic             init,
    input  logic             char_rdy,
    input  logic             irq_ack,
    output logic             active,
    output logic             done,
    output logic             nde_err,
`ifdef AI_FINAL_OVERRUN_EN
    output logic             ovr_err,
`endif
    output logic             pend
);

    localparam int CNT_W = cnt_width(LEN_W, FRAC_SHIFT);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);

    ai_state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] thr_d;
    logic [TMR_W-1:0] tmr;
    logic             conclude;
    logic [MAX_W-1:0] len_ext;
    logic [MAX_W-1:0] thr_base;

    assign len_ext  = MAX_W'(len);
    assign thr_base = (len == '0) ? '0 : len_ext - MAX_W'(1);
    assign thr_d    = CNT_W'(sat_bound(thr_base, FRAC_SHIFT, CNT_W));
    assign active   = (state == ARMED);

`ifdef AI_FINAL_OVERRUN_EN
    logic [CNT_W-1:0] ovr_lim;
    logic [CNT_W-1:0] ovr_d;

    assign ovr_d = CNT_W'(sat_bound(len_ext + MAX_W'(1), FRAC_SHIFT, CNT_W));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Conclude on the edge where the idle timer would step to TIMEOUT-1
    always_comb begin
        state_nxt = state;
        conclude  = 1'b0;
        unique case (state)
            IDLE: begin
                if (init)
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (init) begin
                    state_nxt = ARMED;
                end else if (!char_rdy && tmr == TMR_LAST) begin
                    state_nxt = DONE;
                    conclude  = 1'b1;
                end
            end
            DONE: begin
                if (init)
                    state_nxt = ARMED;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            tmr     <= '0;
            thr     <= '0;
            done    <= 1'b0;
            nde_err <= 1'b0;
            pend    <= 1'b0;
`ifdef AI_FINAL_OVERRUN_EN
            ovr_lim <= '0;
            ovr_err <= 1'b0;
`endif
        end else if (init) begin
            cnt     <= '0;
            tmr     <= '0;
            thr     <= thr_d;
            done    <= 1'b0;
            nde_err <= 1'b0;
            pend    <= 1'b0;
`ifdef AI_FINAL_OVERRUN_EN
            ovr_lim <= ovr_d;
            ovr_err <= 1'b0;
`endif
        end else begin
            if (state == ARMED) begin
                if (char_rdy) begin
                    tmr <= '0;
                    if (cnt != '1)
                        cnt <= cnt + CNT_W'(1);
                end else begin
                    tmr <= tmr + TMR_W'(1);
                end
            end
            if (conclude) begin
                done    <= 1'b1;
                nde_err <= (cnt < thr);
                pend    <= 1'b1;
`ifdef AI_FINAL_OVERRUN_EN
                ovr_err <= (cnt > ovr_lim);
`endif
            end else if (irq_ack) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ai_final_multi.sv
// Multi-channel end-of-utterance verdict block with registered interrupt.
// AI_FINAL_OVERRUN_EN adds the per-channel ovr_err output.
module ai_final_multi
    import ai_final_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int LEN_W      = 16,
    parameter int FRAC_SHIFT = 9,
    parameter int TIMEOUT    = 500000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*LEN_W-1:0] len,
    input  logic [CHANNELS-1:0]       init,
    input  logic [CHANNELS-1:0]       char_rdy,
    input  logic [CHANNELS-1:0]       irq_ack,
    output logic [CHANNELS-1:0]       active,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       nde_err,
    output logic [CHANNELS-1:0]       pend,
`ifdef AI_FINAL_OVERRUN_EN
    output logic [CHANNELS-1:0]       ovr_err,
`endif
    output logic                      irq
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        ai_final_chan #(
            .LEN_W      (LEN_W),
            .FRAC_SHIFT (FRAC_SHIFT),
            .TIMEOUT    (TIMEOUT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .len      (len[i*LEN_W +: LEN_W]),
            .init     (init[i]),
            .char_rdy (char_rdy[i]),
            .irq_ack  (irq_ack[i]),
            .active   (active[i]),
            .done     (done[i]),
            .nde_err  (nde_err[i]),
`ifdef AI_FINAL_OVERRUN_EN
            .ovr_err  (ovr_err[i]),
`endif
            .pend     (pend[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else
            irq <= |pend;
    end

endmodule
